// File: rtl/ex_pkg.sv
// Shared opcodes and multiplier FSM states for the execute stage.
package ex_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_MUL = 4'b1000;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/seq_mul.sv
// Radix-2 shift-add multiplier producing the low DATA_W bits of a*b.
// start_i captures operands; last_o flags the final iteration cycle.
module seq_mul #(
  parameter int DATA_W     = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              last_o,
  output logic [DATA_W-1:0] product_o
);

  localparam int CNT_W = $clog2(MUL_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_CYCLES - 1);

  logic [DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0] mplier_q;
  logic [DATA_W-1:0] acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (abort_i) begin
      busy_q <= 1'b0;
    end else if (start_i) begin
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      // Partial products above DATA_W are never needed, so mcand just drops its top bits.
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (cnt_q == LAST_CNT) busy_q <= 1'b0;
    end
  end

  assign last_o    = busy_q && (cnt_q == LAST_CNT);
  assign product_o = acc_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative multiply, EX/MEM register.
//   state    | meaning
//   MUL_IDLE | no multiply in flight; single-cycle ops pass straight through
//   MUL_BUSY | shift-add iterations running, upstream stalled, bubbles issued
//   MUL_DONE | product ready; EX/MEM loads it and stall drops
module ex_stage
  import ex_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int MUL_CYCLES = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              reg_write_i,
  input  logic              alu_src_i,
  input  logic [3:0]        alu_ctrl_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rt_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic              flush_i,
  input  logic              wb_reg_write_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              stall_o,
  output logic              reg_write_o,
  output logic [REG_AW-1:0] rd_o,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o
);

  mul_state_e        state_q;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] mul_product;
  logic              mul_last;
  logic              mul_start;
  logic              is_mul;

  // EX/MEM beats MEM/WB because it holds the younger value; r0 is never forwarded.
  always_comb begin
    fwd_a = data1_i;
    fwd_b = data2_i;
    if (reg_write_o && rd_o != '0 && rd_o == rs_i)
      fwd_a = result_o;
    else if (wb_reg_write_i && wb_rd_i != '0 && wb_rd_i == rs_i)
      fwd_a = wb_data_i;
    if (reg_write_o && rd_o != '0 && rd_o == rt_i)
      fwd_b = result_o;
    else if (wb_reg_write_i && wb_rd_i != '0 && wb_rd_i == rt_i)
      fwd_b = wb_data_i;
  end

  assign op_b = alu_src_i ? imm_i : fwd_b;

  always_comb begin
    alu_res = '0;
    case (alu_ctrl_i)
      ALU_AND: alu_res = fwd_a & op_b;
      ALU_OR:  alu_res = fwd_a | op_b;
      ALU_ADD: alu_res = fwd_a + op_b;
      ALU_SUB: alu_res = fwd_a - op_b;
      ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
      ALU_NOR: alu_res = ~(fwd_a | op_b);
      default: alu_res = '0;
    endcase
  end

  assign is_mul    = (alu_ctrl_i == ALU_MUL);
  assign mul_start = (state_q == MUL_IDLE) && is_mul && !flush_i;
  assign stall_o   = !rst_i && !flush_i && is_mul && (state_q != MUL_DONE);

  seq_mul #(
    .DATA_W     (DATA_W),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_seq_mul (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (mul_start),
    .abort_i   (flush_i),
    .a_i       (fwd_a),
    .b_i       (op_b),
    .last_o    (mul_last),
    .product_o (mul_product)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= MUL_IDLE;
      reg_write_o <= 1'b0;
      rd_o        <= '0;
      result_o    <= '0;
      zero_o      <= 1'b0;
    end else begin
      // Bubble unless a branch below loads a real result.
      reg_write_o <= 1'b0;
      rd_o        <= '0;
      result_o    <= '0;
      zero_o      <= 1'b0;
      if (flush_i) begin
        state_q <= MUL_IDLE;
      end else begin
        case (state_q)
          MUL_IDLE: begin
            if (is_mul) begin
              state_q <= MUL_BUSY;
            end else begin
              reg_write_o <= reg_write_i;
              rd_o        <= rd_i;
              result_o    <= alu_res;
              zero_o      <= (alu_res == '0);
            end
          end
          MUL_BUSY: begin
            if (mul_last) state_q <= MUL_DONE;
          end
          MUL_DONE: begin
            reg_write_o <= reg_write_i;
            rd_o        <= rd_i;
            result_o    <= mul_product;
            zero_o      <= (mul_product == '0);
            state_q     <= MUL_IDLE;
          end
          default: state_q <= MUL_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage.
module tb_ex_stage;
  import ex_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        reg_write_i;
  logic        alu_src_i;
  logic [3:0]  alu_ctrl_i;
  logic [31:0] data1_i, data2_i, imm_i;
  logic [4:0]  rs_i, rt_i, rd_i;
  logic        flush_i;
  logic        wb_reg_write_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic        stall_o;
  logic        reg_write_o;
  logic [4:0]  rd_o;
  logic [31:0] result_o;
  logic        zero_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  ex_stage dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .reg_write_i    (reg_write_i),
    .alu_src_i      (alu_src_i),
    .alu_ctrl_i     (alu_ctrl_i),
    .data1_i        (data1_i),
    .data2_i        (data2_i),
    .imm_i          (imm_i),
    .rs_i           (rs_i),
    .rt_i           (rt_i),
    .rd_i           (rd_i),
    .flush_i        (flush_i),
    .wb_reg_write_i (wb_reg_write_i),
    .wb_rd_i        (wb_rd_i),
    .wb_data_i      (wb_data_i),
    .stall_o        (stall_o),
    .reg_write_o    (reg_write_o),
    .rd_o           (rd_o),
    .result_o       (result_o),
    .zero_o         (zero_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic rw, input logic src, input logic [3:0] ctrl,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    reg_write_i = rw;
    alu_src_i   = src;
    alu_ctrl_i  = ctrl;
    data1_i     = d1;
    data2_i     = d2;
    imm_i       = imm;
    rs_i        = rs;
    rt_i        = rt;
    rd_i        = rd;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    flush_i = 1'b0;
    wb_reg_write_i = 1'b0;
    wb_rd_i = '0;
    wb_data_i = '0;
    drive(1'b0, 1'b0, ALU_AND, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    step();
    step();
    total++; if (reg_write_o !== 1'b0) begin bad++; $display("FAIL reset_rw got=%b want=0", reg_write_o); end
    total++; if (rd_o !== 5'd0) begin bad++; $display("FAIL reset_rd got=%0d want=0", rd_o); end
    total++; if (result_o !== 32'd0) begin bad++; $display("FAIL reset_result got=%h want=0", result_o); end
    total++; if (zero_o !== 1'b0) begin bad++; $display("FAIL reset_zero got=%b want=0", zero_o); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall_o); end
    rst_i = 1'b0;
  endtask

  task automatic test_add();
    drive(1'b1, 1'b0, ALU_ADD, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3);
    #1;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL add_stall got=%b want=0", stall_o); end
    step();
    total++; if (result_o !== 32'd12) begin bad++; $display("FAIL add_result got=%0d want=12", result_o); end
    total++; if (rd_o !== 5'd3) begin bad++; $display("FAIL add_rd got=%0d want=3", rd_o); end
    total++; if (reg_write_o !== 1'b1) begin bad++; $display("FAIL add_rw got=%b want=1", reg_write_o); end
    total++; if (zero_o !== 1'b0) begin bad++; $display("FAIL add_zero got=%b want=0", zero_o); end
  endtask

  task automatic test_forwarding();
    // EX/MEM holds r3=12; MEM/WB also claims r3=99 but must lose.
    wb_reg_write_i = 1'b1; wb_rd_i = 5'd3; wb_data_i = 32'd99;
    drive(1'b1, 1'b0, ALU_SUB, 32'd0, 32'd2, 32'd0, 5'd3, 5'd4, 5'd6);
    step();
    total++; if (result_o !== 32'd10) begin bad++; $display("FAIL fwd_exmem got=%0d want=10", result_o); end
    // EX/MEM now r6; r3 only available from MEM/WB.
    drive(1'b1, 1'b0, ALU_ADD, 32'd0, 32'd1, 32'd0, 5'd3, 5'd0, 5'd7);
    step();
    total++; if (result_o !== 32'd100) begin bad++; $display("FAIL fwd_memwb got=%0d want=100", result_o); end
    // Write r0 with 11 so EX/MEM has a live r0 entry.
    wb_reg_write_i = 1'b0;
    drive(1'b1, 1'b0, ALU_ADD, 32'd5, 32'd6, 32'd0, 5'd1, 5'd2, 5'd0);
    step();
    total++; if (result_o !== 32'd11 || rd_o !== 5'd0) begin bad++; $display("FAIL r0_write got=%0d/%0d want=11/0", result_o, rd_o); end
    wb_reg_write_i = 1'b1; wb_rd_i = 5'd0; wb_data_i = 32'd9;
    drive(1'b1, 1'b1, ALU_ADD, 32'd0, 32'd0, 32'd4, 5'd0, 5'd0, 5'd9);
    step();
    total++; if (result_o !== 32'd4) begin bad++; $display("FAIL fwd_r0 got=%0d want=4", result_o); end
    wb_reg_write_i = 1'b0; wb_rd_i = '0; wb_data_i = '0;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
  } vec_t;

  task automatic test_alu_ops();
    vec_t v[10];
    v = '{
      '{ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0},
      '{ALU_OR,  32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, 1'b0},
      '{ALU_NOR, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h000F_00CB, 1'b0},
      '{ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1},
      '{ALU_SUB, 32'd3,         32'd5,         32'hFFFF_FFFE, 1'b0},
      '{ALU_SLT, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0},
      '{ALU_SLT, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b1},
      '{ALU_SLT, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1,         1'b0},
      '{ALU_SUB, 32'd4,         32'd4,         32'd0,         1'b1},
      '{4'b0011, 32'd5,         32'd7,         32'd0,         1'b1}
    };
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, v[i].op, v[i].a, v[i].b, 32'd0, 5'd10, 5'd11, 5'd12);
      step();
      total++; if (result_o !== v[i].res) begin bad++; $display("FAIL alu_result[%0d] got=%h want=%h", i, result_o, v[i].res); end
      total++; if (zero_o !== v[i].z) begin bad++; $display("FAIL alu_zero[%0d] got=%b want=%b", i, zero_o, v[i].z); end
    end
  endtask

  task automatic test_back_to_back_mul();
    logic [31:0] exp_res [2];
    int edges, stalls, bubble_bad;
    exp_res[0] = 32'hFFFF_FFFD;
    exp_res[1] = 32'hFFFF_FFF7;
    for (int k = 0; k < 2; k++) begin
      // Second MUL takes A from the first MUL's result via EX/MEM forwarding.
      if (k == 0) drive(1'b1, 1'b0, ALU_MUL, 32'hFFFF_FFFF, 32'd3, 32'd0, 5'd10, 5'd11, 5'd8);
      else        drive(1'b1, 1'b0, ALU_MUL, 32'd0, 32'd3, 32'd0, 5'd8, 5'd11, 5'd9);
      #1;
      edges = 0; stalls = 0; bubble_bad = 0;
      while (edges < 100) begin
        if (stall_o === 1'b1) stalls++;
        step();
        edges++;
        // Disturb forwarding after capture; the captured operands must be used.
        if (edges == 2) begin
          wb_reg_write_i = 1'b1; wb_rd_i = (k == 0) ? 5'd10 : 5'd8; wb_data_i = 32'd7;
        end
        if (reg_write_o === 1'b1) break;
        if (rd_o !== 5'd0 || result_o !== 32'd0 || zero_o !== 1'b0) bubble_bad++;
      end
      wb_reg_write_i = 1'b0; wb_rd_i = '0; wb_data_i = '0;
      total++; if (edges != 34) begin bad++; $display("FAIL mul%0d_latency got=%0d want=34", k, edges); end
      total++; if (stalls != 33) begin bad++; $display("FAIL mul%0d_stall_cycles got=%0d want=33", k, stalls); end
      total++; if (bubble_bad != 0) begin bad++; $display("FAIL mul%0d_bubbles got=%0d want=0", k, bubble_bad); end
      total++; if (result_o !== exp_res[k]) begin bad++; $display("FAIL mul%0d_result got=%h want=%h", k, result_o, exp_res[k]); end
      total++; if (rd_o !== ((k == 0) ? 5'd8 : 5'd9)) begin bad++; $display("FAIL mul%0d_rd got=%0d want=%0d", k, rd_o, (k == 0) ? 8 : 9); end
    end
  endtask

  task automatic test_abort();
    // Flush during BUSY.
    drive(1'b1, 1'b0, ALU_MUL, 32'd5, 32'd6, 32'd0, 5'd10, 5'd11, 5'd13);
    for (int i = 0; i < 11; i++) step();
    flush_i = 1'b1;
    #1;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b want=0", stall_o); end
    step();
    flush_i = 1'b0;
    total++; if (reg_write_o !== 1'b0 || result_o !== 32'd0) begin bad++; $display("FAIL flush_bubble got=%b/%h want=0/0", reg_write_o, result_o); end
    drive(1'b1, 1'b0, ALU_ADD, 32'd2, 32'd3, 32'd0, 5'd10, 5'd11, 5'd14);
    step();
    total++; if (result_o !== 32'd5 || reg_write_o !== 1'b1) begin bad++; $display("FAIL after_flush_add got=%0d/%b want=5/1", result_o, reg_write_o); end
    // Flush in the DONE cycle discards the product.
    drive(1'b1, 1'b0, ALU_MUL, 32'd5, 32'd6, 32'd0, 5'd10, 5'd11, 5'd13);
    for (int i = 0; i < 33; i++) step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    total++; if (reg_write_o !== 1'b0 || result_o !== 32'd0 || rd_o !== 5'd0) begin bad++; $display("FAIL flush_done got=%b/%h/%0d want=0/0/0", reg_write_o, result_o, rd_o); end
    // Reset mid-multiply.
    drive(1'b1, 1'b0, ALU_MUL, 32'd5, 32'd6, 32'd0, 5'd10, 5'd11, 5'd13);
    for (int i = 0; i < 6; i++) step();
    rst_i = 1'b1;
    step();
    total++; if (reg_write_o !== 1'b0 || rd_o !== 5'd0 || result_o !== 32'd0 || zero_o !== 1'b0) begin
      bad++; $display("FAIL rst_mid_mul got=%b/%0d/%h/%b want=0/0/0/0", reg_write_o, rd_o, result_o, zero_o);
    end
    rst_i = 1'b0;
    drive(1'b1, 1'b0, ALU_ADD, 32'd9, 32'd1, 32'd0, 5'd10, 5'd11, 5'd4);
    #1;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL after_rst_stall got=%b want=0", stall_o); end
    step();
    total++; if (result_o !== 32'd10 || rd_o !== 5'd4 || reg_write_o !== 1'b1) begin
      bad++; $display("FAIL after_rst_add got=%0d/%0d/%b want=10/4/1", result_o, rd_o, reg_write_o);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_forwarding();
    test_alu_ops();
    test_back_to_back_mul();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
